// File: rtl/regfile_sb.sv
// regfile_sb: register file with a per-register pending (scoreboard) bit.
// Register 0 always reads as zero. Read ports and the dbg mirror are
// combinational from the array. pend_cnt is a registered popcount of the
// pending bits.
// Optional feature macro: REGFILE_BYPASS_EN. When defined, writeback data and
// a cleared busy flag are forwarded to a matching read port in the same cycle.
module regfile_sb #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned AW      = $clog2(DEPTH),
    parameter int unsigned DBG_IDX = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    output logic             busy1,
    output logic             busy2,
    output logic [AW:0]      pend_cnt,
    output logic [WIDTH-1:0] dbg
);

    localparam logic [AW-1:0] DBG_A = AW'(DBG_IDX);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] pend_q, pend_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wr_en, iss_en;
    logic             inc, dec;

    // Index 0 is never written and never reserved.
    assign wr_en  = we && (wa != '0);
    assign iss_en = iss_valid && (iss_rd != '0);

    // Next pending vector and count; a same-cycle issue beats the writeback clear.
    always_comb begin
        pend_d = pend_q;
        cnt_d  = cnt_q;
        inc    = iss_en && !pend_q[iss_rd];
        dec    = wr_en && pend_q[wa] && !(iss_en && (iss_rd == wa));
        if (wr_en) begin
            pend_d[wa] = 1'b0;
        end
        if (iss_en) begin
            pend_d[iss_rd] = 1'b1;
        end
        case ({inc, dec})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pending bits and count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    // Architectural register array.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wa] <= wd;
        end
    end

    // Combinational read ports, busy flags and debug mirror.
    always_comb begin
        rd1   = regs_q[ra1];
        rd2   = regs_q[ra2];
        busy1 = pend_q[ra1];
        busy2 = pend_q[ra2];
        dbg   = regs_q[DBG_A];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (ra1 == wa)) begin
            rd1   = wd;
            busy1 = 1'b0;
        end
        if (wr_en && (ra2 == wa)) begin
            rd2   = wd;
            busy2 = 1'b0;
        end
`else
        // Without bypass, a write becomes visible only after the clock edge.
`endif
    end

    assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters).
module tb_regfile_sb;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned AW    = 5;

    logic             clk;
    logic             rst;
    logic [AW-1:0]    ra1, ra2, wa, iss_rd;
    logic [WIDTH-1:0] rd1, rd2, wd, dbg;
    logic             we, iss_valid, busy1, busy2;
    logic [AW:0]      pend_cnt;

    int tests;
    int fails;

    regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1       (rd1),
        .rd2       (rd2),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .busy1     (busy1),
        .busy2     (busy2),
        .pend_cnt  (pend_cnt),
        .dbg       (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we        = 1'b0;
        wa        = '0;
        wd        = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        ra1   = '0;
        ra2   = '0;
        idle();

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        ra1 = 5'd10;
        ra2 = 5'd3;
        #1;
        check("rst_rd1", rd1, 32'h0);
        check("rst_rd2", rd2, 32'h0);
        check("rst_busy1", 32'(busy1), 32'h0);
        check("rst_busy2", 32'(busy2), 32'h0);
        check("rst_cnt", 32'(pend_cnt), 32'h0);
        check("rst_dbg", dbg, 32'h0);

        // Write x5=7, then reset overrides a concurrent write and issue
        we = 1'b1; wa = 5'd5; wd = 32'd7;
        tick();
        idle();
        ra1 = 5'd5;
        #1;
        check("wr_x5", rd1, 32'd7);
        rst = 1'b1;
        we = 1'b1; wa = 5'd6; wd = 32'd9;
        iss_valid = 1'b1; iss_rd = 5'd6;
        tick();
        rst = 1'b0;
        idle();
        ra2 = 5'd6;
        #1;
        check("rst_clr_x5", rd1, 32'h0);
        check("rst_ovr_wr", rd2, 32'h0);
        check("rst_ovr_busy", 32'(busy2), 32'h0);
        check("rst_ovr_cnt", 32'(pend_cnt), 32'h0);

        // Index 0 ignores writes and reservations
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick();
        idle();
        ra1 = 5'd0;
        #1;
        check("x0_rd", rd1, 32'h0);
        check("x0_busy", 32'(busy1), 32'h0);
        check("x0_cnt", 32'(pend_cnt), 32'h0);

        // Issue x7, x9; writeback x7
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_rd = 5'd9;
        tick();
        idle();
        ra1 = 5'd7;
        ra2 = 5'd9;
        #1;
        check("iss_cnt2", 32'(pend_cnt), 32'd2);
        check("iss_busy7", 32'(busy1), 32'h1);
        check("iss_busy9", 32'(busy2), 32'h1);
        we = 1'b1; wa = 5'd7; wd = 32'h1234;
        tick();
        idle();
        #1;
        check("wb_cnt1", 32'(pend_cnt), 32'd1);
        check("wb_rd7", rd1, 32'h1234);
        check("wb_busy7", 32'(busy1), 32'h0);
        check("wb_busy9", 32'(busy2), 32'h1);

        // Re-issue of a pending register
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        idle();
        #1;
        check("reiss_cnt", 32'(pend_cnt), 32'd1);
        check("reiss_busy", 32'(busy2), 32'h1);

        // Bypass behaviour on x3
        we = 1'b1; wa = 5'd3; wd = 32'h11;
        tick();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        idle();
        ra2 = 5'd3;
        #1;
        check("x3_cnt", 32'(pend_cnt), 32'd2);
        we = 1'b1; wa = 5'd3; wd = 32'hABCD;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_rd2", rd2, 32'hABCD);
        check("byp_busy2", 32'(busy2), 32'h0);
`else
        check("nobyp_rd2", rd2, 32'h11);
        check("nobyp_busy2", 32'(busy2), 32'h1);
`endif
        tick();
        idle();
        #1;
        check("x3_rd2_next", rd2, 32'hABCD);
        check("x3_busy2_next", 32'(busy2), 32'h0);
        check("x3_cnt_next", 32'(pend_cnt), 32'd1);

        // Issue x4, then same-cycle issue and writeback on x4
        iss_valid = 1'b1; iss_rd = 5'd4;
        tick();
        #1;
        check("x4_cnt", 32'(pend_cnt), 32'd2);
        we = 1'b1; wa = 5'd4; wd = 32'd5;
        tick();
        idle();
        ra1 = 5'd4;
        #1;
        check("same_rd", rd1, 32'd5);
        check("same_busy", 32'(busy1), 32'h1);
        check("same_cnt", 32'(pend_cnt), 32'd2);

        // Issue x11 while retiring x9: count unchanged
        iss_valid = 1'b1; iss_rd = 5'd11;
        we = 1'b1; wa = 5'd9; wd = 32'h99;
        tick();
        idle();
        ra1 = 5'd11;
        ra2 = 5'd9;
        #1;
        check("swap_cnt", 32'(pend_cnt), 32'd2);
        check("swap_busy11", 32'(busy1), 32'h1);
        check("swap_busy9", 32'(busy2), 32'h0);
        check("swap_rd9", rd2, 32'h99);

        // Write to a non-pending register leaves the count alone; dbg mirror
        we = 1'b1; wa = 5'd10; wd = 32'h55;
        #1;
        check("dbg_before", dbg, 32'h0);
        tick();
        idle();
        #1;
        check("dbg_x10", dbg, 32'h55);
        check("np_cnt", 32'(pend_cnt), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
